// File: rtl/snapshot_fifo.sv
// snapshot_fifo: captures {i_b,i_a} from an upstream latch stage on every
// falling edge of its (synchronised) latch enable, and queues the snapshots
// in a DEPTH-entry FIFO for a ready/valid consumer.
// Optional feature: define SNAPSHOT_MISMATCH_EN to flag a head entry whose
// A and B halves differ; otherwise o_mismatch is tied low.
module snapshot_fifo #(
  parameter int V     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst,
  input  logic                     i_en,
  input  logic [V-1:0]             i_a,
  input  logic [V-1:0]             i_b,
  output logic [2*V-1:0]           o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic                     o_mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 2 * V;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  logic          en_meta_q;
  logic          en_s_q;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          write_s;
  logic [DW-1:0] head_s;

  // Two-flop synchroniser: the only place raw i_en is sampled.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
    end else begin
      en_meta_q <= i_en;
      en_s_q    <= en_meta_q;
    end
  end

  // Capture FSM next state: one PUSH cycle per falling edge of en_s.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (en_s_q) state_d = S_OPEN;
        else        state_d = S_IDLE;
      end
      S_OPEN: begin
        if (!en_s_q) state_d = S_PUSH;
        else         state_d = S_OPEN;
      end
      S_PUSH: begin
        if (en_s_q) state_d = S_OPEN;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a push into a full FIFO only lands if a pop frees a slot
  // in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    empty_s    = (count_q == {CW{1'b0}});
    full_s     = (count_q == CW'(DEPTH));
    push_s     = (state_q == S_PUSH);
    pop_s      = !empty_s && i_ready;
    write_s    = push_s && (!full_s || pop_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    if (write_s) begin
      mem_d[wr_ptr_q] = {i_b, i_a};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (write_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !write_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, pointer, count, sticky-overflow and storage registers.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Output view of the head entry; data is forced to zero when empty.
  always_comb begin
    if (empty_s) begin
      head_s = {DW{1'b0}};
    end else begin
      head_s = mem_q[rd_ptr_q];
    end
  end

  assign o_data     = head_s;
  assign o_valid    = !empty_s;
  assign o_count    = count_q;
  assign o_full     = full_s;
  assign o_empty    = empty_s;
  assign o_overflow = overflow_q;

`ifdef SNAPSHOT_MISMATCH_EN
  assign o_mismatch = !empty_s && (head_s[V-1:0] != head_s[DW-1:V]);
`else
  assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_snapshot_fifo.sv
// Directed self-checking bench for snapshot_fifo (V=8, DEPTH=4).
module tb_snapshot_fifo;

  logic        clk;
  logic        arst;
  logic        en;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        mismatch;

  int checks = 0;
  int errors = 0;

`ifdef SNAPSHOT_MISMATCH_EN
  localparam logic MM_EXP = 1'b1;
`else
  localparam logic MM_EXP = 1'b0;
`endif

  snapshot_fifo #(.V(8), .DEPTH(4)) dut (
    .i_clk      (clk),
    .i_arst     (arst),
    .i_en       (en),
    .i_a        (a),
    .i_b        (b),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (overflow),
    .o_mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    en = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse i_en with given data; leaves caller at the negedge where i_en fell.
  task automatic en_pulse(input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic capture(input logic [7:0] va, input logic [7:0] vb);
    en_pulse(va, vb);
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check(tag, {16'h0, data}, {16'h0, exp});
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    int n;
    arst = 1'b1;
    en = 1'b0;
    a = 8'h00;
    b = 8'h00;
    ready = 1'b0;
    #2;
    // Reset state
    check("rst_count", {29'h0, count}, 32'd0);
    check("rst_empty", {31'h0, empty}, 32'd1);
    check("rst_full", {31'h0, full}, 32'd0);
    check("rst_valid", {31'h0, valid}, 32'd0);
    check("rst_data", {16'h0, data}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'd0);
    check("rst_mm", {31'h0, mismatch}, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // Single capture latency and data
    en_pulse(8'hFF, 8'hFF);
    n = 0;
    while (!valid && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("lat_valid", {31'h0, valid}, 32'd1);
    check("lat_data", {16'h0, data}, 32'h0000FFFF);
    check("lat_count", {29'h0, count}, 32'd1);
    check("lat_mm", {31'h0, mismatch}, 32'd0);

    // Five captures into DEPTH=4 with no pops
    do_reset();
    capture(8'h01, 8'h10);
    capture(8'h02, 8'h20);
    capture(8'h03, 8'h30);
    capture(8'h04, 8'h40);
    check("pre_ovf", {31'h0, overflow}, 32'd0);
    capture(8'h05, 8'h50);
    check("ovf_full", {31'h0, full}, 32'd1);
    check("ovf_count", {29'h0, count}, 32'd4);
    check("ovf_flag", {31'h0, overflow}, 32'd1);
    pop_check("drain0", 16'h1001);
    pop_check("drain1", 16'h2002);
    pop_check("drain2", 16'h3003);
    pop_check("drain3", 16'h4004);
    check("drained_empty", {31'h0, empty}, 32'd1);
    check("ovf_sticky", {31'h0, overflow}, 32'd1);
    check("drained_data", {16'h0, data}, 32'h0);

    // Full with simultaneous push and pop
    do_reset();
    capture(8'hA1, 8'h1A);
    capture(8'hA2, 8'h2A);
    capture(8'hA3, 8'h3A);
    capture(8'hA4, 8'h4A);
    en_pulse(8'hA5, 8'h5A);
    repeat (3) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    check("pp_count", {29'h0, count}, 32'd4);
    check("pp_ovf", {31'h0, overflow}, 32'd0);
    pop_check("pp0", 16'h2AA2);
    pop_check("pp1", 16'h3AA3);
    pop_check("pp2", 16'h4AA4);
    pop_check("pp3", 16'h5AA5);

    // Mismatch flag
    do_reset();
    capture(8'h00, 8'hFF);
    check("mm_diff", {31'h0, mismatch}, {31'h0, MM_EXP});
    do_reset();
    capture(8'h5A, 8'h5A);
    check("mm_same", {31'h0, mismatch}, 32'd0);

    // Reset with three entries held and a push pending
    do_reset();
    capture(8'h11, 8'h11);
    capture(8'h22, 8'h22);
    capture(8'h33, 8'h33);
    check("mid_count", {29'h0, count}, 32'd3);
    en_pulse(8'h44, 8'h44);
    repeat (3) @(negedge clk);
    arst = 1'b1;
    #1;
    check("mid_rst_count", {29'h0, count}, 32'd0);
    check("mid_rst_valid", {31'h0, valid}, 32'd0);
    check("mid_rst_data", {16'h0, data}, 32'h0);
    @(negedge clk);
    arst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_nopush", {29'h0, count}, 32'd0);
    capture(8'h66, 8'h77);
    check("post_rst_push", {29'h0, count}, 32'd1);
    check("post_rst_data", {16'h0, data}, 32'h00007766);

    // i_ready held while empty
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("uf_count", {29'h0, count}, 32'd0);
      check("uf_data", {16'h0, data}, 32'h0);
    end
    ready = 1'b0;
    capture(8'h12, 8'h34);
    check("uf_after", {29'h0, count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
